// File: rtl/rock_spawner_pkg.sv
// Shared game constants: screen bounds, heading encoding and the spawn-position helper.
// Pure declarations, no state.
package rock_spawner_pkg;

  localparam int         NUM_ROCKS_DEF = 8;
  localparam logic [9:0] SCREEN_W      = 10'd640;
  localparam logic [9:0] SCREEN_H      = 10'd480;
  localparam logic [9:0] X_MAX         = 10'd639;
  localparam logic [9:0] Y_MAX         = 10'd479;

  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } dir_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    dir_t       dx;
    dir_t       dy;
  } spawn_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SELECT,
    S_LAUNCH,
    S_CONFIRM
  } state_e;

  function automatic logic [9:0] fold_x(input logic [9:0] r);
    return (r >= SCREEN_W) ? r - 10'd512 : r;
  endfunction

  // 480..511 cannot be folded down by 512 without going negative, so pin them to the bottom row
  function automatic logic [9:0] fold_y(input logic [9:0] r);
    if (r >= 10'd512) return r - 10'd512;
    if (r >= SCREEN_H) return Y_MAX;
    return r;
  endfunction

  function automatic spawn_t spawn_from_lfsr(input logic [15:0] l);
    spawn_t s;
    dir_t   in_d;
    dir_t   side_d;
    s          = '0;
    in_d.neg   = 1'b0;
    in_d.mag   = (l[13:12] == 2'd0) ? 2'd1 : l[13:12];
    side_d.neg = l[14];
    side_d.mag = l[15:14];
    case (l[1:0])
      2'd0: begin s.x = 10'd0; s.y = fold_y(l[11:2]); s.dx = in_d; s.dy = side_d; end
      2'd1: begin s.x = X_MAX; s.y = fold_y(l[11:2]); s.dx = in_d; s.dx.neg = 1'b1; s.dy = side_d; end
      2'd2: begin s.y = 10'd0; s.x = fold_x(l[11:2]); s.dy = in_d; s.dx = side_d; end
      default: begin s.y = Y_MAX; s.x = fold_x(l[11:2]); s.dy = in_d; s.dy.neg = 1'b1; s.dx = side_d; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11; steps every frame.
// Output is the register itself; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk60hz,
  input  logic        reset,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/rock_spawner.sv
// Rock pool scheduler: paces spawns, picks the lowest free slot with a random edge entry, kills hit rocks.
// Start fires 2 frames after the timer expires; kills pulse 1 frame after a new hit on a live rock.
module rock_spawner
  import rock_spawner_pkg::*;
#(
  parameter int          NUM_ROCKS      = NUM_ROCKS_DEF,
  parameter int          SPAWN_PERIOD   = 90,
  parameter int          MIN_PERIOD     = 30,
  parameter int          PERIOD_STEP    = 8,
  parameter int          KILLS_PER_STEP = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk60hz,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [NUM_ROCKS-1:0] i_in_use,
  input  logic [NUM_ROCKS-1:0] i_hit,
  output logic [NUM_ROCKS-1:0] o_start,
  output logic [NUM_ROCKS-1:0] o_kill,
  output logic [9:0]           o_init_x,
  output logic [9:0]           o_init_y,
  output logic [2:0]           o_dir_x,
  output logic [2:0]           o_dir_y,
  output logic [15:0]          o_kill_count,
  output logic                 o_busy
);

  localparam logic [15:0] P_SPAWN = 16'(SPAWN_PERIOD);
  localparam logic [15:0] P_MIN   = 16'(MIN_PERIOD);
  localparam logic [15:0] P_STEP  = 16'(PERIOD_STEP);
  localparam logic [15:0] P_KPS   = 16'(KILLS_PER_STEP);

  state_e               r_state, w_next_state;
  logic [15:0]          r_timer, r_interval, r_step_cnt, r_kill_count;
  logic [NUM_ROCKS-1:0] r_start, r_kill, r_hit, r_slot_oh;
  logic [NUM_ROCKS-1:0] w_kill_set, w_free, w_sel_oh;
  logic                 w_found, r_wait, w_slot_killed, w_slot_up;
  logic [15:0]          w_lfsr;
  spawn_t               r_spawn;
  logic [4:0]           w_pop;
  logic [15:0]          w_total, w_steps, w_rem, w_dec, w_next_interval;
  logic [16:0]          w_cnt_sum;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk60hz (clk60hz),
    .reset   (reset),
    .o_lfsr  (w_lfsr)
  );

  // A held hit only kills once: compare against last frame's hit
  assign w_kill_set    = i_hit & i_in_use & ~r_hit;
  assign w_free        = ~i_in_use & ~r_kill;
  assign w_slot_killed = |(w_kill_set & r_slot_oh);
  assign w_slot_up     = |(i_in_use & r_slot_oh);

  always_comb begin
    w_found  = 1'b0;
    w_sel_oh = '0;
    for (int i = NUM_ROCKS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_found     = 1'b1;
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_ROCKS; i++) w_pop = w_pop + {4'd0, w_kill_set[i]};
  end

  // Several kills in one frame can cross a step boundary; carry the remainder forward
  assign w_total         = r_step_cnt + {11'd0, w_pop};
  assign w_steps         = w_total / P_KPS;
  assign w_rem           = w_total - w_steps * P_KPS;
  assign w_dec           = w_steps * P_STEP;
  assign w_next_interval = (r_interval < P_MIN + w_dec) ? P_MIN : r_interval - w_dec;
  assign w_cnt_sum       = {1'b0, r_kill_count} + {12'd0, w_pop};

  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (i_enable) w_next_state = S_WAIT;
      S_WAIT:    if (!i_enable) w_next_state = S_IDLE;
                 else if (r_timer == 16'd0) w_next_state = S_SELECT;
      S_SELECT:  if (!i_enable) w_next_state = S_IDLE;
                 else w_next_state = w_found ? S_LAUNCH : S_WAIT;
      S_LAUNCH:  if (!i_enable) w_next_state = S_IDLE;
                 else w_next_state = w_slot_killed ? S_WAIT : S_CONFIRM;
      S_CONFIRM: if (!i_enable) w_next_state = S_IDLE;
                 else if (w_slot_up || r_wait) w_next_state = S_WAIT;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE) && (r_state != S_WAIT);
  end

  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      r_timer    <= P_SPAWN;
      r_interval <= P_SPAWN;
      r_step_cnt <= '0;
      r_start    <= '0;
      r_slot_oh  <= '0;
      r_spawn    <= '0;
      r_wait     <= 1'b0;
    end else begin
      r_start <= '0;
      if (r_state == S_IDLE ||
          (w_next_state != r_state && (w_next_state == S_WAIT || w_next_state == S_IDLE)))
        r_timer <= r_interval;
      else if (r_state == S_WAIT && r_timer != 16'd0)
        r_timer <= r_timer - 16'd1;
      if (r_state == S_SELECT && w_next_state == S_LAUNCH) begin
        r_start   <= w_sel_oh;
        r_slot_oh <= w_sel_oh;
        r_spawn   <= spawn_from_lfsr(w_lfsr);
      end
      r_wait <= (r_state == S_CONFIRM);
      if (w_pop != 5'd0) begin
        r_interval <= w_next_interval;
        r_step_cnt <= w_rem;
      end
    end
  end

  always_ff @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      r_hit        <= '0;
      r_kill       <= '0;
      r_kill_count <= '0;
    end else begin
      r_hit        <= i_hit;
      r_kill       <= w_kill_set;
      r_kill_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign o_start      = r_start;
  assign o_kill       = r_kill;
  assign o_init_x     = r_spawn.x;
  assign o_init_y     = r_spawn.y;
  assign o_dir_x      = r_spawn.dx;
  assign o_dir_y      = r_spawn.dy;
  assign o_kill_count = r_kill_count;

endmodule

// File: tb/tb_rock_spawner.sv
// Directed bench for rock_spawner: spawn timing, slot choice, kills, difficulty, saturation, aborts, reset.
module tb_rock_spawner;

  logic        clk60hz = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [7:0]  i_in_use;
  logic [7:0]  i_hit;
  logic [7:0]  o_start;
  logic [7:0]  o_kill;
  logic [9:0]  o_init_x;
  logic [9:0]  o_init_y;
  logic [2:0]  o_dir_x;
  logic [2:0]  o_dir_y;
  logic [15:0] o_kill_count;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  always #5 clk60hz = ~clk60hz;

  rock_spawner dut (
    .clk60hz      (clk60hz),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_in_use     (i_in_use),
    .i_hit        (i_hit),
    .o_start      (o_start),
    .o_kill       (o_kill),
    .o_init_x     (o_init_x),
    .o_init_y     (o_init_y),
    .o_dir_x      (o_dir_x),
    .o_dir_y      (o_dir_y),
    .o_kill_count (o_kill_count),
    .o_busy       (o_busy)
  );

  // Reference LFSR; m_prev is the value the DUT saw in the frame before the latest edge
  always @(posedge clk60hz or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'h0000;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_prev <= m_lfsr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk60hz);
  endtask

  function automatic int ref_fold_x(input int r);
    return (r >= 640) ? r - 512 : r;
  endfunction

  function automatic int ref_fold_y(input int r);
    if (r >= 512) return r - 512;
    if (r >= 480) return 479;
    return r;
  endfunction

  task automatic check_spawn(input string tag);
    logic [15:0] l;
    int          r, ex, ey;
    logic [1:0]  inmag;
    logic [2:0]  side, edx, edy;
    logic [1:0]  inward;
    l     = m_prev;
    r     = int'(l[11:2]);
    inmag = (l[13:12] == 2'd0) ? 2'd1 : l[13:12];
    side  = {l[14], l[15:14]};
    case (l[1:0])
      2'd0: begin ex = 0;   ey = ref_fold_y(r); edx = {1'b0, inmag}; edy = side; end
      2'd1: begin ex = 639; ey = ref_fold_y(r); edx = {1'b1, inmag}; edy = side; end
      2'd2: begin ey = 0;   ex = ref_fold_x(r); edy = {1'b0, inmag}; edx = side; end
      default: begin ey = 479; ex = ref_fold_x(r); edy = {1'b1, inmag}; edx = side; end
    endcase
    chk({tag, "_x"}, o_init_x, ex);
    chk({tag, "_y"}, o_init_y, ey);
    chk({tag, "_dx"}, o_dir_x, edx);
    chk({tag, "_dy"}, o_dir_y, edy);
    chk({tag, "_x_range"}, o_init_x <= 10'd639, 1);
    chk({tag, "_y_range"}, o_init_y <= 10'd479, 1);
    inward = (l[1] == 1'b0) ? o_dir_x[1:0] : o_dir_y[1:0];
    chk({tag, "_inward_nz"}, inward != 2'd0, 1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (o_start == 8'h00 && n < 300) begin
      @(negedge clk60hz);
      n++;
    end
    chk({tag, "_start_seen"}, o_start != 8'h00, 1);
  endtask

  // Frames from the end of one SELECT to the next SELECT; equals reload value + 1
  task automatic measure_gap(input string tag, output int gap);
    int n;
    n = 0;
    while (!o_busy && n < 300) begin
      @(negedge clk60hz);
      n++;
    end
    chk({tag, "_busy_seen"}, o_busy, 1);
    step(1);
    gap = 0;
    while (!o_busy && gap < 300) begin
      @(negedge clk60hz);
      gap++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    reset    = 1'b1;
    i_enable = 1'b0;
    i_in_use = 8'h00;
    i_hit    = 8'h00;
    step(2);
    chk("rst_start", o_start, 8'h00);
    chk("rst_kill", o_kill, 8'h00);
    chk("rst_init_x", o_init_x, 10'd0);
    chk("rst_init_y", o_init_y, 10'd0);
    chk("rst_dir_x", o_dir_x, 3'd0);
    chk("rst_dir_y", o_dir_y, 3'd0);
    chk("rst_kill_count", o_kill_count, 16'd0);
    chk("rst_busy", o_busy, 1'b0);
    reset = 1'b0;
    step(1);

    // First spawn: 92 edges after the edge that samples enable, seen on the 93rd negedge
    i_enable = 1'b1;
    n = 0;
    while (o_start == 8'h00 && n < 300) begin
      @(negedge clk60hz);
      n++;
    end
    chk("first_start_latency", n, 93);
    chk("first_start_slot", o_start, 8'h01);
    chk("first_busy_launch", o_busy, 1'b1);
    check_spawn("first");
    step(1);
    chk("first_start_one_cycle", o_start, 8'h00);
    chk("first_busy_confirm", o_busy, 1'b1);
    i_in_use = 8'h01;
    step(1);
    chk("first_confirm_done", o_busy, 1'b0);

    // Pool full: attempt dropped, SELECT lasts one frame, timer reloads to 90
    i_in_use = 8'hFF;
    n = 0;
    while (!o_busy && n < 300) begin
      @(negedge clk60hz);
      n++;
    end
    chk("full_select_seen", o_busy, 1'b1);
    chk("full_no_start", o_start, 8'h00);
    step(1);
    chk("full_busy_drop", o_busy, 1'b0);
    chk("full_no_start_after", o_start, 8'h00);
    n = 0;
    while (!o_busy && n < 300) begin
      @(negedge clk60hz);
      n++;
    end
    chk("full_reload_gap", n, 91);

    // Now in SELECT: lowest free slot of 8'h0B is slot 2
    i_in_use = 8'h0B;
    step(1);
    chk("slot2_start", o_start, 8'h04);
    check_spawn("slot2");
    step(1);
    i_in_use = 8'h0F;
    step(1);
    chk("slot2_confirm_done", o_busy, 1'b0);

    // Held hit on a live rock kills exactly once
    i_hit  = 8'h08;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 0) chk("hit3_first_kill", o_kill, 8'h08);
      if (o_kill != 8'h00) pulses++;
    end
    chk("hit3_pulses", pulses, 1);
    chk("hit3_count", o_kill_count, 16'd1);
    i_hit    = 8'h00;
    i_in_use = 8'hFF;
    step(1);

    // Seven simultaneous kills bring the total to 8: one difficulty step
    i_hit = 8'h7F;
    step(1);
    chk("multi_kill", o_kill, 8'h7F);
    chk("count8", o_kill_count, 16'd8);
    i_hit = 8'h00;
    step(1);
    measure_gap("step1", n);
    chk("gap_after_8_kills", n, 83);

    for (int b = 0; b < 7; b++) begin
      i_hit = 8'hFF;
      step(1);
      i_hit = 8'h00;
      step(1);
    end
    chk("count64", o_kill_count, 16'd64);
    measure_gap("floor", n);
    chk("gap_at_floor", n, 31);
    i_hit = 8'hFF;
    step(1);
    chk("kill_all", o_kill, 8'hFF);
    i_hit = 8'h00;
    step(1);
    chk("count72", o_kill_count, 16'd72);
    measure_gap("floor_hold", n);
    chk("gap_floor_hold", n, 31);

    // Kill counter saturation: 72 + 8182*8 = 0xFFF8
    for (int b = 0; b < 8182; b++) begin
      i_hit = 8'hFF;
      step(1);
      i_hit = 8'h00;
      step(1);
    end
    chk("count_fff8", o_kill_count, 16'hFFF8);
    i_hit = 8'hFF;
    step(1);
    chk("count_saturate", o_kill_count, 16'hFFFF);
    i_hit = 8'h00;
    step(1);
    i_hit = 8'hFF;
    step(1);
    chk("count_saturate_hold", o_kill_count, 16'hFFFF);
    i_hit = 8'h00;
    step(1);

    // Hit lands on the slot being launched: kill wins, back to WAIT
    i_in_use = 8'hFE;
    wait_start("lk");
    chk("lk_slot0", o_start, 8'h01);
    i_hit    = 8'h01;
    i_in_use = 8'hFF;
    step(1);
    chk("lk_kill0", o_kill, 8'h01);
    chk("lk_start_off", o_start, 8'h00);
    chk("lk_state_wait", o_busy, 1'b0);
    i_hit    = 8'h00;
    i_in_use = 8'hFE;
    step(1);

    // enable drops during LAUNCH: straight to IDLE
    wait_start("ab");
    chk("ab_slot0", o_start, 8'h01);
    i_enable = 1'b0;
    step(1);
    chk("ab_start_done", o_start, 8'h00);
    chk("ab_idle", o_busy, 1'b0);
    i_enable = 1'b1;

    // Reset asserted in CONFIRM clears everything without waiting for a clock
    wait_start("rs");
    chk("rs_slot0", o_start, 8'h01);
    i_hit    = 8'h02;
    i_in_use = 8'hFF;
    step(1);
    chk("rs_pre_busy", o_busy, 1'b1);
    chk("rs_pre_kill", o_kill, 8'h02);
    #2 reset = 1'b1;
    #1;
    chk("rs_start", o_start, 8'h00);
    chk("rs_kill", o_kill, 8'h00);
    chk("rs_busy", o_busy, 1'b0);
    chk("rs_kill_count", o_kill_count, 16'd0);
    chk("rs_init_x", o_init_x, 10'd0);
    chk("rs_init_y", o_init_y, 10'd0);
    chk("rs_dir_x", o_dir_x, 3'd0);
    chk("rs_dir_y", o_dir_y, 3'd0);
    step(1);
    reset = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
